// File: rtl/systolic_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : systolic_ctrl
// Brief    : Sequencer for an N x N output-stationary systolic tile: clears the
//            PEs, streams K operand reads, skews row fire, drains result rows.
// Revision : 1.0
// ============================================================================
module systolic_ctrl #(
    parameter int N  = 4,
    parameter int KW = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [KW-1:0]        k_len,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    output logic                 pe_rstn,
    output logic                 rd_en,
    output logic [KW-1:0]        rd_addr,
    output logic [N-1:0]         row_fire,
    output logic                 out_valid,
    output logic [$clog2(N)-1:0] out_row
);

    localparam int RW = $clog2(N);
    // Phase counter must reach 2N-2 during FLUSH and N-1 during DRAIN.
    localparam int PW = $clog2(2 * N);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_FEED  = 3'd2,
        S_FLUSH = 3'd3,
        S_DRAIN = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    logic [KW-1:0]   addr_q, addr_d;
    logic [PW-1:0]   ph_q, ph_d;
    logic [N-1:0]    fire_q, fire_d;
    logic            kill;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            addr_q  <= '0;
            ph_q    <= '0;
            fire_q  <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            addr_q  <= addr_d;
            ph_q    <= ph_d;
            fire_q  <= fire_d;
        end
    end

    assign kill = abort && (state_q != S_IDLE);

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        addr_d  = addr_q;
        ph_d    = ph_q;

        case (state_q)
            S_IDLE: begin
                addr_d = '0;
                ph_d   = '0;
                if (start && !abort) begin
                    k_d     = k_len;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                addr_d  = '0;
                ph_d    = '0;
                state_d = (k_q != '0) ? S_FEED : S_DRAIN;
            end
            S_FEED: begin
                if (addr_q == k_q - KW'(1)) begin
                    addr_d  = '0;
                    state_d = S_FLUSH;
                end else begin
                    addr_d = addr_q + KW'(1);
                end
            end
            S_FLUSH: begin
                // Read latency + row skew + column propagation.
                if (ph_q == PW'(2 * N - 2)) begin
                    ph_d    = '0;
                    state_d = S_DRAIN;
                end else begin
                    ph_d = ph_q + PW'(1);
                end
            end
            S_DRAIN: begin
                if (ph_q == PW'(N - 1)) begin
                    ph_d    = '0;
                    state_d = S_DONE;
                end else begin
                    ph_d = ph_q + PW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                addr_d  = '0;
                ph_d    = '0;
            end
        endcase

        if (kill) begin
            state_d = S_IDLE;
            addr_d  = '0;
            ph_d    = '0;
        end
    end

    // Skew line: stage 0 tracks the buffer read latency, stage r adds r cycles.
    always_comb begin
        fire_d = {fire_q[N-2:0], rd_en};
        if (kill || (state_q == S_CLEAR)) begin
            fire_d = '0;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign pe_rstn   = !(rst || (state_q == S_CLEAR));
    assign rd_en     = (state_q == S_FEED);
    assign rd_addr   = rd_en ? addr_q : '0;
    assign row_fire  = fire_q;
    assign out_valid = (state_q == S_DRAIN);
    assign out_row   = out_valid ? ph_q[RW-1:0] : '0;

endmodule
`default_nettype wire

// File: tb/tb_systolic_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_systolic_ctrl
// Brief    : Scoreboard bench for systolic_ctrl against a per-tile timing model.
// Revision : 1.0
// ============================================================================
module tb_systolic_ctrl;

    localparam int N  = 4;
    localparam int KW = 8;
    localparam int RW = 2;
    localparam int VW = 5 + KW + N + RW;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic [KW-1:0] k_len;
    logic          busy;
    logic          done;
    logic          pe_rstn;
    logic          rd_en;
    logic [KW-1:0] rd_addr;
    logic [N-1:0]  row_fire;
    logic          out_valid;
    logic [RW-1:0] out_row;

    systolic_ctrl #(.N(N), .KW(KW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .k_len     (k_len),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .pe_rstn   (pe_rstn),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .row_fire  (row_fire),
        .out_valid (out_valid),
        .out_row   (out_row)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int val;
    } ev_t;

    ev_t addr_q[$];
    int  done_q[$];
    int  cyc;
    int  n_cmp;
    int  n_bad;
    bit  have_tile;
    int  c0;
    int  kk;
    int  last;

    function automatic logic [VW-1:0] pack(input logic b, input logic dn, input logic pe,
                                            input logic re, input logic [KW-1:0] ad,
                                            input logic [N-1:0] rf, input logic ov,
                                            input logic [RW-1:0] orow);
        return {b, dn, pe, re, ad, rf, ov, orow};
    endfunction

    function automatic bit tile_busy(input int c);
        return have_tile && (c >= c0) && (c <= last);
    endfunction

    // Cycle d after the CLEAR cycle of the current tile, from the phase lengths.
    function automatic logic [VW-1:0] expect_at(input int c);
        logic          b, dn, pe, re, ov;
        logic [KW-1:0] ad;
        logic [N-1:0]  rf;
        logic [RW-1:0] orow;
        int            d, dr0, dcyc;
        b = 1'b0; dn = 1'b0; pe = !rst; re = 1'b0; ov = 1'b0;
        ad = '0; rf = '0; orow = '0;
        if (tile_busy(c)) begin
            d    = c - c0;
            b    = 1'b1;
            pe   = (d != 0);
            dr0  = (kk > 0) ? kk + 2 * N : 1;
            dcyc = (kk > 0) ? kk + 3 * N : N + 1;
            re   = (d >= 1) && (d <= kk);
            ad   = re ? KW'(d - 1) : '0;
            for (int r = 0; r < N; r++) begin
                rf[r] = (kk > 0) && (d >= 2 + r) && (d <= kk + 1 + r);
            end
            ov   = (d >= dr0) && (d < dr0 + N);
            orow = ov ? RW'(d - dr0) : '0;
            dn   = (d == dcyc);
        end
        return pack(b, dn, pe, re, ad, rf, ov, orow);
    endfunction

    task automatic check_vec(input string name, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, got, exp);
        end
    endtask

    // Monitor: full output snapshot every cycle, plus scoreboard pops on strobes.
    always @(negedge clk) begin
        ev_t ev;
        int  dc;
        check_vec("snapshot", pack(busy, done, pe_rstn, rd_en, rd_addr, row_fire, out_valid, out_row),
                  expect_at(cyc));
        if (rd_en === 1'b1) begin
            if (addr_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL addr_unexpected cyc=%0d got=%0d exp=none", cyc, rd_addr);
            end else begin
                ev = addr_q.pop_front();
                check_int("addr_cycle", cyc, ev.cyc);
                check_int("addr_value", int'(rd_addr), ev.val);
            end
        end
        if (done === 1'b1) begin
            if (done_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL done_unexpected cyc=%0d got=1 exp=0", cyc);
            end else begin
                dc = done_q.pop_front();
                check_int("done_cycle", cyc, dc);
            end
        end
    end

    task automatic purge_after(input int c);
        while (addr_q.size() > 0 && addr_q[$].cyc > c) void'(addr_q.pop_back());
        while (done_q.size() > 0 && done_q[$] > c) void'(done_q.pop_back());
    endtask

    task automatic cycle(input bit s, input bit a, input logic [KW-1:0] k);
        start = s;
        abort = a;
        k_len = k;
        if (tile_busy(cyc)) begin
            if (a) begin
                last = cyc;
                purge_after(cyc);
            end
        end else if (s && !a && !rst) begin
            have_tile = 1'b1;
            c0        = cyc + 1;
            kk        = int'(k);
            last      = c0 + ((kk > 0) ? kk + 3 * N : N + 1);
            for (int i = 0; i < kk; i++) addr_q.push_back('{c0 + 1 + i, i});
            done_q.push_back(last);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_idle(input int bound, input bit noise);
        int n;
        n = 0;
        while (tile_busy(cyc) && n < bound) begin
            cycle(noise && ($urandom_range(0, 5) == 0), 1'b0, KW'($urandom));
            n++;
        end
        if (tile_busy(cyc)) begin
            n_cmp++;
            n_bad++;
            $display("FAIL run_timeout cyc=%0d got=busy exp=idle", cyc);
        end
    endtask

    task automatic reset_mid();
        start = 1'b0;
        abort = 1'b0;
        #2;
        rst = 1'b1;
        if (have_tile && last >= cyc) last = cyc - 1;
        purge_after(cyc - 1);
        #1;
        check_vec("async_reset", pack(busy, done, pe_rstn, rd_en, rd_addr, row_fire, out_valid, out_row),
                  pack(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0));
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        int at;
        rst = 1'b1; start = 1'b0; abort = 1'b0; k_len = '0;
        cyc = 0; n_cmp = 0; n_bad = 0; have_tile = 1'b0;
        c0 = 0; kk = 0; last = -1;

        repeat (3) cycle(1'b0, 1'b0, '0);
        rst = 1'b0;
        repeat (2) cycle(1'b0, 1'b0, KW'($urandom));

        // Basic tile, then empty tile.
        cycle(1'b1, 1'b0, 8'd3);
        run_idle(400, 1'b0);
        cycle(1'b0, 1'b0, '0);
        cycle(1'b1, 1'b0, 8'd0);
        run_idle(400, 1'b0);

        // Start pulsed mid-FEED must be ignored.
        cycle(1'b1, 1'b0, 8'd5);
        cycle(1'b0, 1'b0, '0);
        cycle(1'b0, 1'b0, '0);
        cycle(1'b1, 1'b0, 8'd9);
        run_idle(400, 1'b0);

        // Abort in the third FLUSH cycle, then a normal K=2 tile.
        cycle(1'b1, 1'b0, 8'd4);
        repeat (4 + 3) cycle(1'b0, 1'b0, KW'($urandom));
        cycle(1'b0, 1'b1, KW'($urandom));
        cycle(1'b1, 1'b0, 8'd2);
        run_idle(400, 1'b0);

        // Abort together with start in IDLE leaves the block idle.
        cycle(1'b1, 1'b1, 8'd5);
        repeat (3) cycle(1'b0, 1'b0, '0);

        // Asynchronous reset mid-FEED, then recovery with K=1.
        cycle(1'b1, 1'b0, 8'd6);
        repeat (3) cycle(1'b0, 1'b0, '0);
        reset_mid();
        cycle(1'b0, 1'b0, '0);
        rst = 1'b0;
        cycle(1'b1, 1'b0, 8'd1);
        run_idle(400, 1'b0);

        // Longest reduction.
        cycle(1'b1, 1'b0, 8'd255);
        run_idle(400, 1'b1);

        // Randomized tiles with stray starts and occasional aborts.
        for (int t = 0; t < 40; t++) begin
            repeat ($urandom_range(0, 2)) cycle(1'b0, $urandom_range(0, 3) == 0, KW'($urandom));
            cycle(1'b1, 1'b0, ($urandom_range(0, 7) == 0) ? 8'd0 : KW'($urandom_range(1, 20)));
            if ($urandom_range(0, 4) == 0) begin
                at = $urandom_range(0, last - c0);
                repeat (at) cycle($urandom_range(0, 5) == 0, 1'b0, KW'($urandom));
                cycle(1'b0, 1'b1, KW'($urandom));
            end
            run_idle(400, 1'b1);
        end

        repeat (3) cycle(1'b0, 1'b0, '0);
        check_int("addr_left", addr_q.size(), 0);
        check_int("done_left", done_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/systolic_ctrl.md
SYSTOLIC_CTRL -- requirements
Module: systolic_ctrl

Interface
REQ-001 SHALL have parameter N, default 4: PE array dimension (N x N), N >= 2.
REQ-002 SHALL have parameter KW, default 8: width of reduction length and read address.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  begin one tile computation, sampled only in IDLE.
REQ-006 SHALL have port k_len  input  KW  reduction length K, latched when start is accepted.
REQ-007 SHALL have port abort  input  1  synchronous cancel of the current tile.
REQ-008 SHALL have port busy  output  1  high in every state except IDLE.
REQ-009 SHALL have port done  output  1  one-cycle completion pulse.
REQ-010 SHALL have port pe_rstn  output  1  active-low synchronous clear to all PEs.
REQ-011 SHALL have port rd_en  output  1  operand-buffer read strobe (A and W buffers share it).
REQ-012 SHALL have port rd_addr  output  KW  operand-buffer read address.
REQ-013 SHALL have port row_fire  output  N  fire into the left-edge PE of each row, skewed.
REQ-014 SHALL have port out_valid  output  1  PE result row is being read out.
REQ-015 SHALL have port out_row  output  clog2(N)  index of the row being read out.

Function
REQ-016 SHALL implement states IDLE, CLEAR, FEED, FLUSH, DRAIN, DONE.
REQ-017 IDLE: start=1 SHALL latch k_len and go to CLEAR; start in any other state SHALL be ignored.
REQ-018 CLEAR: lasts 1 cycle with pe_rstn=0; next state SHALL be FEED if K>0, else DRAIN.
REQ-019 FEED: lasts exactly K cycles with rd_en=1 and rd_addr=0,1,...,K-1 (one per cycle); next state SHALL be FLUSH.
REQ-020 rd_addr SHALL be 0 whenever rd_en=0; K=2^KW-1 SHALL give a last address of 2^KW-2 with no wrap.
REQ-021 Buffer read latency is 1 cycle, so row_fire[0] SHALL equal rd_en delayed by 1 cycle.
REQ-022 row_fire[r] SHALL equal row_fire[0] delayed by r cycles, via a registered delay line.
REQ-023 FLUSH: lasts 2N-1 cycles (1 read latency + N-1 row skew + N-1 column propagation); next state SHALL be DRAIN.
REQ-024 DRAIN: lasts N cycles with out_valid=1 and out_row=0..N-1 ascending; next state SHALL be DONE.
REQ-025 DONE: lasts 1 cycle with done=1; next state SHALL be IDLE.
REQ-026 With start accepted at edge t, CLEAR SHALL be cycle t+1 and done SHALL be high in cycle t+2+K+3N-1 (K>0) or t+2+N (K=0).
REQ-027 abort in any non-IDLE state SHALL take priority over all transitions: next state IDLE, the delay line is cleared, and no done pulse is issued.
REQ-028 abort in IDLE SHALL have no effect; abort and start in the same IDLE cycle SHALL leave the block in IDLE.
REQ-029 out_valid, out_row and rd_en SHALL be 0 outside their states.
REQ-030 The row_fire delay line SHALL also be cleared in CLEAR.

Reset
REQ-031 rst=1 SHALL immediately force state IDLE and set busy, done, rd_en, rd_addr, row_fire, out_valid and out_row to 0, independent of clk.
REQ-032 pe_rstn SHALL be 0 while rst=1, and otherwise 0 only in CLEAR.
REQ-033 The latched K SHALL reset to 0.
REQ-034 rst asserted mid-operation SHALL discard the tile; after release the block SHALL accept a new start normally.

Verification
REQ-035 N=4, K=3, start at edge t -> CLEAR at t+1; rd_addr 0,1,2 at t+2..t+4; row_fire[0] high t+3..t+5; row_fire[3] high t+6..t+8; out_valid t+12..t+15 with out_row 0..3; done at t+16.
REQ-036 N=4, K=0 -> pe_rstn=0 at t+1; no rd_en and no row_fire; out_valid t+2..t+5; done at t+6.
REQ-037 start pulsed during FEED of a K=5 tile -> ignored; rd_addr sequence and done timing unchanged; one done only.
REQ-038 abort in the 3rd FLUSH cycle -> IDLE next cycle; row_fire=0; no done; a following start with K=2 completes at t+1+K+3N.
REQ-039 rst asserted asynchronously mid-FEED (between edges) -> all outputs 0 and pe_rstn=0 before the next edge; after release, start with K=1 gives done at t+14.
REQ-040 N=4, K=255 -> rd_addr runs 0..254 contiguously; done at t+268.
